// File: rtl/alu_pkg.sv
// Shared ALU operation codes and arbiter state encoding.
package alu_pkg;

  // ALU control code; any code not listed below evaluates as an add.
  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_ADD = 3'b000;
  localparam alu_op_t ALU_SUB = 3'b001;
  localparam alu_op_t ALU_AND = 3'b010;
  localparam alu_op_t ALU_OR  = 3'b011;
  localparam alu_op_t ALU_SLT = 3'b101;

  // Arbiter FSM: IDLE accepts one request, RESP holds its result.
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_t;

endpackage : alu_pkg

// File: rtl/alu.sv
// Combinational ALU: add/sub/and/or/unsigned set-less-than, W-bit wrap.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  alu_op_t        op_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [W-1:0]   y_o,
  output logic           zero_o
);

  // Operation select; unlisted codes fall back to add.
  always_comb begin
    y_o = a_i + b_i;
    case (op_i)
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_SLT: y_o = {{(W-1){1'b0}}, (a_i < b_i)};
      default: y_o = a_i + b_i;
    endcase
  end

  assign zero_o = (y_o == '0);

endmodule : alu

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready clients.
// One request is accepted in IDLE; its registered result is held in RESP
// until the owning client takes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,

  input  logic         req_valid_0,
  output logic         req_ready_0,
  input  logic [2:0]   req_op_0,
  input  logic [W-1:0] req_a_0,
  input  logic [W-1:0] req_b_0,

  input  logic         req_valid_1,
  output logic         req_ready_1,
  input  logic [2:0]   req_op_1,
  input  logic [W-1:0] req_a_1,
  input  logic [W-1:0] req_b_1,

  output logic         rsp_valid_0,
  input  logic         rsp_ready_0,
  output logic [W-1:0] rsp_data_0,
  output logic         rsp_eq_0,

  output logic         rsp_valid_1,
  input  logic         rsp_ready_1,
  output logic [W-1:0] rsp_data_1,
  output logic         rsp_eq_1,

  output logic         busy
);

  arb_state_t   state_q, state_d;
  logic         prio_q,  prio_d;   // client favoured when both are valid
  logic         owner_q, owner_d;  // client the held result belongs to
  logic [W-1:0] res_q,   res_d;
  logic         eq_q,    eq_d;

  logic         gnt1;
  logic         rdy0, rdy1;
  alu_op_t      alu_op;
  logic [W-1:0] alu_a, alu_b, alu_y;
  logic         alu_zero;

  // Client 1 wins when it is the only requester, or both request and it has priority.
  assign gnt1 = req_valid_1 & (~req_valid_0 | prio_q);

  // Operand mux feeding the shared ALU from the granted client.
  assign alu_op = gnt1 ? req_op_1 : req_op_0;
  assign alu_a  = gnt1 ? req_a_1  : req_a_0;
  assign alu_b  = gnt1 ? req_b_1  : req_b_0;

  alu #(.W(W)) u_alu (
    .op_i   (alu_op),
    .a_i    (alu_a),
    .b_i    (alu_b),
    .y_o    (alu_y),
    .zero_o (alu_zero)
  );

  // State, priority pointer and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      res_q   <= '0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      res_q   <= res_d;
      eq_q    <= eq_d;
    end
  end

  // Next-state logic: grant and capture in IDLE, release on owner acceptance in RESP.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    res_d   = res_q;
    eq_d    = eq_q;
    rdy0    = 1'b0;
    rdy1    = 1'b0;
    case (state_q)
      IDLE: begin
        rdy0 = req_valid_0 & ~gnt1;
        rdy1 = gnt1;
        if (req_valid_0 | req_valid_1) begin
          state_d = RESP;
          owner_d = gnt1;
          prio_d  = ~gnt1;
          res_d   = alu_y;
          eq_d    = alu_zero;
        end
      end
      RESP: begin
        if (owner_q ? rsp_ready_1 : rsp_ready_0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is forced low while reset is held, even though state already reads IDLE.
  assign req_ready_0 = rdy0 & rst_n;
  assign req_ready_1 = rdy1 & rst_n;

  assign busy        = (state_q == RESP);
  assign rsp_valid_0 = busy & ~owner_q;
  assign rsp_valid_1 = busy &  owner_q;
  assign rsp_data_0  = rsp_valid_0 ? res_q : '0;
  assign rsp_data_1  = rsp_valid_1 ? res_q : '0;
  assign rsp_eq_0    = rsp_valid_0 & eq_q;
  assign rsp_eq_1    = rsp_valid_1 & eq_q;

endmodule : alu_arbiter
